// File: rtl/aer_packetizer.sv
// AER packetizer: captures a spike vector on each timestep strobe, scans it one channel per
// cycle and queues address-event words in a FWFT FIFO. Define AER_TIMESTAMP_EN to prefix words with the timestep.
//
// state | meaning
// IDLE  | waiting for a step strobe; shadow vector holds the previous frame
// SCAN  | examining shadow[idx] and pushing an event when the bit is set
`timescale 1ns/1ps
module aer_packetizer #(
    parameter int N_CH       = 16,
    parameter int CH_W       = 4,
    parameter int TS_W       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic [N_CH-1:0]      spikes,
`ifdef AER_TIMESTAMP_EN
    output logic [TS_W+CH_W-1:0] ev_data,
`else
    output logic [CH_W-1:0]      ev_data,
`endif
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic                 busy,
    output logic                 step_done,
    output logic [7:0]           overrun_cnt,
    output logic [7:0]           drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
`ifdef AER_TIMESTAMP_EN
    localparam int EW = TS_W + CH_W;
`else
    localparam int EW = CH_W;
`endif

    if (N_CH != (1 << CH_W) || TS_W < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("aer_packetizer: inconsistent parameters");
    end

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] idx_q;
    logic [N_CH-1:0] shadow_q;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [EW-1:0]   push_word;

    logic last_idx;
    logic accept;
    logic overrun;
    logic push_req;
    logic push_ok;
    logic drop;
    logic pop;
    logic full;
    logic empty;

    assign last_idx = (idx_q == CH_W'(N_CH - 1));
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // pop is gated by non-empty, so a same-cycle push/pop on an empty FIFO cannot occur
    assign pop      = !empty && ev_ready;
    assign push_req = (state_q == SCAN) && shadow_q[idx_q];
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && !push_ok;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        overrun = 1'b0;
        case (state_q)
            IDLE: begin
                if (step) begin
                    accept  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                overrun = step;
                if (last_idx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (state_q == SCAN && last_idx) begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign push_word = {ts_q, idx_q};
`else
    assign push_word = idx_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            step_done   <= 1'b0;
            overrun_cnt <= 8'd0;
            drop_cnt    <= 8'd0;
        end else begin
            state_q   <= state_d;
            step_done <= (state_q == SCAN) && last_idx;
            if (accept) begin
                shadow_q <= spikes;
                idx_q    <= '0;
            end else if (state_q == SCAN) begin
                idx_q <= idx_q + CH_W'(1);
            end
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            if (overrun && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
            if (drop && drop_cnt != 8'hFF)       drop_cnt    <= drop_cnt + 8'd1;
        end
    end

    // Storage needs no reset: the read port is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_word;
    end

    assign ev_valid = !empty;
    assign ev_data  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign busy     = (state_q == SCAN);

endmodule

// File: tb/tb_aer_packetizer.sv
// Self-checking bench for aer_packetizer: directed frames plus randomized traffic against
// a cycle-number based event model. Works with or without AER_TIMESTAMP_EN.
`timescale 1ns/1ps
module tb_aer_packetizer;
    localparam int N_CH       = 16;
    localparam int CH_W       = 4;
    localparam int TS_W       = 8;
    localparam int FIFO_DEPTH = 8;
`ifdef AER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
    localparam int EW    = TS_W + CH_W;
`else
    localparam bit TS_EN = 1'b0;
    localparam int EW    = CH_W;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            step;
    logic [N_CH-1:0] spikes;
    logic [EW-1:0]   ev_data;
    logic            ev_valid;
    logic            ev_ready;
    logic            busy;
    logic            step_done;
    logic [7:0]      overrun_cnt;
    logic [7:0]      drop_cnt;

    aer_packetizer #(.N_CH(N_CH), .CH_W(CH_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .spikes(spikes),
        .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .busy(busy), .step_done(step_done),
        .overrun_cnt(overrun_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [EW-1:0] mk(input int ts, input int ch);
        if (TS_EN) return EW'((ts % 256) * N_CH + ch);
        return EW'(ch);
    endfunction

    // Model: a frame accepted at clock edge s pushes channel c at edge s+1+c,
    // ends at edge s+N_CH (done pulse and timestep bump), and is busy after edges s..s+N_CH-1.
    int              k = 0;
    int              s = -1000;
    int              ts_m = 0;
    int              ov_m = 0;
    int              dr_m = 0;
    logic [N_CH-1:0] sh_m = '0;
    logic [EW-1:0]   q[$];

    always @(posedge clk) begin
        bit scanning, pop_m, push_m, full_m;
        k++;
        if (!rst_n) begin
            q.delete();
            s = -1000; ts_m = 0; ov_m = 0; dr_m = 0; sh_m = '0;
        end else begin
            scanning = (k >= s + 1) && (k <= s + N_CH);
            pop_m    = (q.size() != 0) && ev_ready;
            push_m   = scanning && sh_m[k - s - 1];
            full_m   = (q.size() >= FIFO_DEPTH);
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                if (!full_m || pop_m) q.push_back(mk(ts_m, k - s - 1));
                else if (dr_m < 255) dr_m++;
            end
            if (step) begin
                if (scanning) begin
                    if (ov_m < 255) ov_m++;
                end else begin
                    s    = k;
                    sh_m = spikes;
                end
            end
            if (scanning && k == s + N_CH) ts_m = (ts_m + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_ev_valid",  ev_valid,    q.size() != 0);
            chk("m_ev_data",   ev_data,     (q.size() != 0) ? q[0] : '0);
            chk("m_busy",      busy,        (k >= s) && (k <= s + N_CH - 1));
            chk("m_step_done", step_done,   k == s + N_CH);
            chk("m_overrun",   overrun_cnt, ov_m);
            chk("m_drop",      drop_cnt,    dr_m);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_step(input logic [N_CH-1:0] sp);
        step   = 1'b1;
        spikes = sp;
        @(posedge clk);
        tick();
        step = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst_n = 1'b0; step = 1'b0; spikes = '0; ev_ready = 1'b0;
        repeat (3) @(posedge clk);
        tick();
        rst_n = 1'b1;
        chk("rst_ev_valid",  ev_valid,    0);
        chk("rst_ev_data",   ev_data,     0);
        chk("rst_busy",      busy,        0);
        chk("rst_step_done", step_done,   0);
        chk("rst_overrun",   overrun_cnt, 0);
        chk("rst_drop",      drop_cnt,    0);

        // two-event frame: ch0 two cycles after the strobe, ch15 with the done pulse
        ev_ready = 1'b1;
        do_step(16'h8001);
        tick();
        chk("f1_ch0_valid", ev_valid, 1);
        chk("f1_ch0_data",  ev_data,  0);
        repeat (15) tick();
        chk("f1_ch15_valid", ev_valid,  1);
        chk("f1_ch15_data",  ev_data,   15);
        chk("f1_done",       step_done, 1);
        tick();
        chk("f1_done_pulse", step_done, 0);

        // full frame into a stalled consumer: 8 kept, 8 dropped
        ev_ready = 1'b0;
        do_step(16'hFFFF);
        repeat (16) tick();
        chk("f2_drop",  drop_cnt,  8);
        chk("f2_done",  step_done, 1);
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("f2_drain_%0d", i), ev_data, mk(1, i));
            tick();
        end
        chk("f2_empty", ev_valid, 0);

        // back-to-back strobes: second one rejected
        spikes = '0;
        step   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        tick();
        step  = 1'b0;
        dones = 0;
        repeat (25) begin
            if (step_done) dones++;
            tick();
        end
        chk("ovr_cnt",   overrun_cnt, 1);
        chk("ovr_dones", dones,       1);

        // reset in the middle of a scan
        ev_ready = 1'b0;
        do_step(16'hFFFF);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   ev_valid,    0);
        chk("mid_rst_data",    ev_data,     0);
        chk("mid_rst_busy",    busy,        0);
        chk("mid_rst_done",    step_done,   0);
        chk("mid_rst_overrun", overrun_cnt, 0);
        chk("mid_rst_drop",    drop_cnt,    0);
        repeat (3) tick();
        rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            tick();
            if (step_done) dones++;
        end
        chk("mid_rst_no_done", dones,    0);
        chk("mid_rst_empty",   ev_valid, 0);

        // 256 empty frames wrap the timestep back to 0
        ev_ready = 1'b1;
        repeat (256) begin
            do_step('0);
            repeat (17) tick();
        end
        chk("wrap_no_events", ev_valid, 0);
        do_step(16'h0002);
        tick();
        tick();
        chk("wrap_valid", ev_valid, 1);
        chk("wrap_data",  ev_data,  mk(0, 1));
        repeat (16) tick();

        // full FIFO with consumer ready: push and pop share cycles, nothing lost
        ev_ready = 1'b0;
        do_step(16'hFFFF);
        repeat (8) tick();
        ev_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_order_%0d", i), ev_data, mk(1, i));
            tick();
        end
        chk("full_no_drop", drop_cnt, 0);
        chk("full_empty",   ev_valid, 0);

        for (int i = 0; i < 400; i++) begin
            ev_ready = 1'($urandom_range(0, 1));
            step     = ($urandom_range(0, 5) == 0);
            spikes   = N_CH'($urandom);
            tick();
        end
        step     = 1'b0;
        ev_ready = 1'b1;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/aer_packetizer.md
AER_PACKETIZER -- requirements
Module: aer_packetizer

Interface
REQ-001 SHALL have parameter N_CH, default 16, number of spike channels (power of 2, >=2).
REQ-002 SHALL have parameter CH_W, default 4, channel address width (log2 N_CH).
REQ-003 SHALL have parameter TS_W, default 8, timestep counter width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth (power of 2).
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port step  input  1  timestep strobe; spike vector valid this cycle.
REQ-008 SHALL have port spikes  input  N_CH  registered spike bits from the per-channel encoders.
REQ-009 SHALL have port ev_data  output  EW  event word: {timestep, channel} or {channel} (see Configuration).
REQ-010 SHALL have port ev_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port ev_ready  input  1  consumer accepts ev_data when ev_valid && ev_ready.
REQ-012 SHALL have port busy  output  1  high while scanning.
REQ-013 SHALL have port step_done  output  1  one-cycle pulse at scan completion.
REQ-014 SHALL have port overrun_cnt  output  8  saturating count of step strobes rejected while busy.
REQ-015 SHALL have port drop_cnt  output  8  saturating count of events lost to a full FIFO.

Function
REQ-016 SHALL implement FSM states IDLE and SCAN.
REQ-017 In IDLE, step=1 SHALL latch spikes into a shadow register, load scan index 0, and enter SCAN next cycle.
REQ-018 In SCAN, SHALL examine exactly one channel per cycle, index 0 to N_CH-1, ascending; scan lasts exactly N_CH cycles.
REQ-019 For each examined channel with shadow bit 1, SHALL push one event with channel=index and timestep=current counter value.
REQ-020 After index N_CH-1, SHALL return to IDLE, pulse step_done for one cycle, and increment the timestep counter modulo 2^TS_W.
REQ-021 busy SHALL equal (state==SCAN).
REQ-022 step=1 while in SCAN SHALL be ignored (vector not captured, counter unchanged) and SHALL increment overrun_cnt, saturating at 255.
REQ-023 step=1 in the same cycle as the final SCAN cycle SHALL be treated as an overrun.
REQ-024 Latency: step at cycle t with spikes[0]=1 SHALL give ev_valid=1 at cycle t+2 with channel 0.
REQ-025 The FIFO SHALL be first-word-fall-through; ev_data SHALL be stable while ev_valid && !ev_ready.
REQ-026 A push SHALL succeed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-027 A push that cannot succeed SHALL discard the event and increment drop_cnt, saturating at 255; scanning SHALL NOT stall.
REQ-028 Simultaneous push and pop on an empty FIFO SHALL be illegal by construction: ev_valid=0 implies no pop.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra pointer bit.

Reset
REQ-030 On rst_n=0, SHALL asynchronously force state=IDLE, scan index=0, shadow=0, timestep=0, FIFO empty, ev_valid=0, ev_data=0, busy=0, step_done=0, overrun_cnt=0, drop_cnt=0.
REQ-031 Reset asserted mid-scan SHALL discard any partial scan and all FIFO contents; no step_done SHALL be issued.
REQ-032 The first step after reset release SHALL be stamped timestep 0.

Configuration
REQ-033 With macro AER_TIMESTAMP_EN defined, EW SHALL be TS_W+CH_W and ev_data SHALL be {timestep[TS_W-1:0], channel[CH_W-1:0]}.
REQ-034 Without AER_TIMESTAMP_EN, EW SHALL be CH_W, ev_data SHALL be channel only, and the timestep counter SHALL be absent; step_done still marks frame boundaries.

Verification
REQ-035 Defaults, ev_ready=1, step with spikes=16'h8001 -> events ch0 at t+2 and ch15 at t+17, step_done at t+17, timestep 0 in both.
REQ-036 ev_ready=0, step with spikes=16'hFFFF -> 8 events stored, drop_cnt=8, step_done after 16 scan cycles; then ev_ready=1 drains ch0..ch7 in order.
REQ-037 step on consecutive cycles t and t+1 -> second strobe rejected, overrun_cnt=1, only one step_done.
REQ-038 256 steps with spikes=0 -> no events, timestep wraps to 0, the next event is stamped 0 (AER_TIMESTAMP_EN).
REQ-039 rst_n pulsed low at scan index 5 of spikes=16'hFFFF -> ev_valid=0 immediately, all counters 0, no step_done.
REQ-040 FIFO full, ev_ready=1, scan pushing each cycle -> no drops, drop_cnt stays 0, order preserved.
